fft_frame_sched: RTL and testbench

- Frame-level scheduler in front of the radix-2 SDF `fft` core. Two sample sources share the core.
- Requesters are granted whole frames of 2^N contiguous samples under round-robin arbitration.
- The block generates `start_ip`, muxes the granted channel onto `ip`, and tags each frame with its source channel.
- When the core signals output, the block marks the output window with the matching channel ID so downstream logic can route `op_raw`/`op_shuffled`.

---
 rtl/fft_frame_sched.sv | 108 ++++++++++
 tb/tb_fft_frame_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: round-robin frame scheduler feeding an SDF FFT core, tagging output windows with source channel
module fft_frame_sched #(
    parameter int N    = 4,
    parameter int DW   = 32,
    parameter int TAGD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    output logic          start_ip,
    output logic [DW-1:0] ip,
    input  logic          op_ready,
    output logic          out_valid,
    output logic          out_chan,
    output logic          busy,
    output logic          err
);
    localparam int AW = $clog2(TAGD);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;
    localparam logic [AW:0] FULL = (AW + 1)'(TAGD);

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  in_cnt_q, in_cnt_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          last_grant_q, last_grant_d;
    logic [TAGD-1:0] tag_q, tag_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [N-2:0]  out_cnt_q, out_cnt_d;
    logic          out_chan_q, out_chan_d;
    logic          err_q, err_d;
    logic          ov_last, bad, pop, dec, push, pick;

    // next-state: grant decision, tag FIFO push/pop, output window tracking
    always_comb begin
        ov_last = out_valid_q & (out_cnt_q == '1);
        // op_ready is only legal with a tag waiting and no window open (or the window's final cycle)
        bad  = op_ready & ((cnt_q == '0) | (out_valid_q & ~ov_last));
        pop  = op_ready & ~bad;
        dec  = (state_q == S_IDLE) | (in_cnt_q == '1);
        // a pop in this cycle frees a slot for this cycle's push
        push = dec & ((cnt_q != FULL) | pop) & (req0 | req1);
        pick = (req0 & req1) ? ~last_grant_q : req1;
        state_d      = dec ? (push ? S_STREAM : S_IDLE) : state_q;
        in_cnt_d     = dec ? '0 : in_cnt_q + N'(1);
        gnt0_d       = dec ? push & ~pick : gnt0_q;
        gnt1_d       = dec ? push & pick : gnt1_q;
        last_grant_d = push ? pick : last_grant_q;
        tag_d        = tag_q;
        if (push) tag_d[wr_q] = pick;
        wr_d         = wr_q + AW'(push);
        rd_d         = rd_q + AW'(pop);
        cnt_d        = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        out_valid_d  = pop | (out_valid_q & ~ov_last);
        out_cnt_d    = pop ? '0 : (out_valid_q ? out_cnt_q + (N - 1)'(1) : out_cnt_q);
        out_chan_d   = pop ? tag_q[rd_q] : out_chan_q;
        err_d        = err_q | bad;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            last_grant_q <= 1'b1;
            tag_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_cnt_q    <= '0;
            out_chan_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_cnt_q    <= out_cnt_d;
            out_chan_q   <= out_chan_d;
            err_q        <= err_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign start_ip  = (gnt0_q | gnt1_q) & (in_cnt_q == '0);
    assign ip        = gnt0_q ? data0 : (gnt1_q ? data1 : '0);
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign busy      = gnt0_q | gnt1_q | (cnt_q != '0) | out_valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: vector table, directed sequences and random traffic against a queue-based reference model
module tb_fft_frame_sched;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int TAGD = 4;
    localparam int FL   = 1 << N;
    localparam int OW   = 1 << (N - 1);

    logic clk = 1'b0, rst_n = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, op_ready = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic gnt0, gnt1, start_ip, out_valid, out_chan, busy, err;
    logic [DW-1:0] ip;

    fft_frame_sched #(.N(N), .DW(DW), .TAGD(TAGD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .start_ip(start_ip), .ip(ip),
        .op_ready(op_ready), .out_valid(out_valid), .out_chan(out_chan),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // reference model: current owner/position of the input frame, tag queue, remaining output-window cycles
    bit model_ok = 0;
    int m_owner, m_pos, m_last, m_left, m_chan;
    bit m_err;
    int m_tags[$];

    // sampled DUT outputs of the latest cycle
    logic s_g0, s_g1, s_st, s_ov, s_ch, s_busy, s_err;
    logic [DW-1:0] s_ip;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_update();
        bit bad, pop, push;
        int ch, occ;
        if (!rst_n) begin
            m_owner = -1; m_pos = 0; m_last = 1; m_left = 0; m_chan = 0; m_err = 0;
            m_tags.delete();
            model_ok = 1;
            return;
        end
        bad  = op_ready && (m_tags.size() == 0 || m_left > 1);
        pop  = op_ready && !bad;
        push = 0;
        ch   = 0;
        occ  = m_tags.size() - (pop ? 1 : 0);
        if (m_owner < 0 || m_pos == FL - 1) begin
            if (occ < TAGD && (req0 || req1)) begin
                ch = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
                m_owner = ch; m_pos = 0; m_last = ch; push = 1;
            end else begin
                m_owner = -1; m_pos = 0;
            end
        end else m_pos++;
        if (pop) begin
            m_chan = m_tags.pop_front();
            m_left = OW;
        end else if (m_left > 0) m_left--;
        if (push) m_tags.push_back(ch);
        if (bad) m_err = 1;
    endtask

    task automatic check_model();
        logic [DW-1:0] e_ip;
        e_ip = (m_owner == 0) ? data0 : ((m_owner == 1) ? data1 : '0);
        chk("gnt0", s_g0, m_owner == 0);
        chk("gnt1", s_g1, m_owner == 1);
        chk("start_ip", s_st, m_owner >= 0 && m_pos == 0);
        chk("ip", s_ip, e_ip);
        chk("out_valid", s_ov, m_left > 0);
        if (m_left > 0) chk("out_chan", s_ch, m_chan);
        chk("busy", s_busy, m_owner >= 0 || m_tags.size() > 0 || m_left > 0);
        chk("err", s_err, m_err);
    endtask

    // one clock: sample on the falling edge, advance the model on the rising edge, return just after it
    task automatic step();
        @(negedge clk);
        s_g0 = gnt0; s_g1 = gnt1; s_st = start_ip; s_ip = ip;
        s_ov = out_valid; s_ch = out_chan; s_busy = busy; s_err = err;
        if (model_ok) check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; op_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic       rst_n;
        logic       req0;
        logic       req1;
        logic       op;
        logic [5:0] exp;
    } vec_t;

    vec_t tv[18];

    initial begin
        int cnt_g0, cnt_g1, cnt_st, last_st, idle_g;
        int ops[$];
        int order[$];
        int oorder[$];
        bit prev_op;

        // inputs {rst_n,req0,req1,op_ready}, expected {gnt0,gnt1,start_ip,out_valid,busy,err}
        tv[0]  = {4'b1010, 6'b000000};
        tv[1]  = {4'b1000, 6'b011010};
        tv[2]  = {4'b1000, 6'b010010};
        tv[3]  = {4'b1000, 6'b010010};
        tv[4]  = {4'b1000, 6'b010010};
        tv[5]  = {4'b1000, 6'b010010};
        tv[6]  = {4'b1000, 6'b010010};
        tv[7]  = {4'b1000, 6'b010010};
        tv[8]  = {4'b0000, 6'b010010};
        tv[9]  = {4'b1000, 6'b000000};
        tv[10] = {4'b1010, 6'b000000};
        tv[11] = {4'b1000, 6'b011010};
        tv[12] = {4'b0000, 6'b010010};
        tv[13] = {4'b1001, 6'b000000};
        tv[14] = {4'b1000, 6'b000001};
        tv[15] = {4'b1100, 6'b000001};
        tv[16] = {4'b1000, 6'b101011};
        tv[17] = {4'b1000, 6'b100011};

        apply_reset();
        for (int i = 0; i < 18; i++) begin
            rst_n = tv[i].rst_n; req0 = tv[i].req0; req1 = tv[i].req1; op_ready = tv[i].op;
            step();
            chk($sformatf("vec%0d", i), {s_g0, s_g1, s_st, s_ov, s_busy, s_err}, tv[i].exp);
        end

        // single channel-0 frame carrying 0..15
        apply_reset();
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        cnt_g0 = 0; cnt_g1 = 0; cnt_st = 0;
        for (int k = 0; k < 20; k++) begin
            data0 = DW'(k);
            step();
            if (s_g0) begin
                cnt_g0++;
                chk("ip_seq", s_ip, k);
            end
            if (s_st) begin
                cnt_st++;
                chk("start_ip_sample0", s_ip, 0);
            end
            if (s_g1) cnt_g1++;
        end
        chk("gnt0_cycles", cnt_g0, FL);
        chk("start_count", cnt_st, 1);
        chk("gnt1_cycles", cnt_g1, 0);

        // both requesting, core answers three frames after each start
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        last_st = -1; prev_op = 0;
        for (int c = 0; c < 260; c++) begin
            data0 = $urandom; data1 = $urandom;
            op_ready = (ops.size() > 0 && ops[0] == c);
            if (op_ready) void'(ops.pop_front());
            step();
            if (s_st) begin
                order.push_back(int'(s_g1));
                ops.push_back(c + 3 * FL);
                if (last_st >= 0) chk("start_gap", c - last_st, FL);
                last_st = c;
            end
            if (prev_op) oorder.push_back(int'(s_ch));
            prev_op = op_ready;
        end
        op_ready = 1'b0; req0 = 1'b0; req1 = 1'b0;
        chk("frames_granted_min", order.size() >= 6, 1);
        for (int i = 0; i < 6 && i < order.size(); i++) chk($sformatf("grant_order%0d", i), order[i], i % 2);
        chk("windows_min", oorder.size() >= 3, 1);
        for (int i = 0; i < 3 && i < oorder.size(); i++) chk($sformatf("out_chan_order%0d", i), oorder[i], i % 2);

        // tag FIFO fills after TAGD frames; one op_ready releases one more grant
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        cnt_st = 0; idle_g = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            cnt_st += int'(s_st);
            if (c >= 70) idle_g += int'(s_g0 | s_g1);
        end
        chk("full_frames", cnt_st, TAGD);
        chk("full_gnt_idle", idle_g, 0);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        cnt_st = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            cnt_st += int'(s_st);
        end
        chk("release_one_frame", cnt_st, 1);

        // random traffic against the model
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            data0 = $urandom; data1 = $urandom;
            if (m_owner == 0) req0 = $urandom_range(0, 1) == 1;
            else if (!req0) req0 = $urandom_range(0, 2) == 0;
            if (m_owner == 1) req1 = $urandom_range(0, 1) == 1;
            else if (!req1) req1 = $urandom_range(0, 2) == 0;
            if (m_tags.size() > 0 && m_left <= 1) op_ready = $urandom_range(0, 4) == 0;
            else op_ready = $urandom_range(0, 149) == 0;
            rst_n = !($urandom_range(0, 399) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
